// File: rtl/led_mode_seq.sv
// ---------------------------------------------------------------------------
// led_mode_seq
//
// Turns a raw push-button into the LED mode for the output stage and
// generates the blink waveform that the output stage drives in blink mode.
// Path: 2-flop synchronizer -> debouncer -> rising-edge detect ->
// mode stepper (OFF -> ON -> BLINK -> OFF), plus a blink prescaler.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a new level (>= 2)
//   BLINK_HALF      : cycles per pattern1 half-period, normal rate
//                     (>= 4, multiple of 4)
//
// Ports
//   clk         : single clock, rising edge
//   rst         : synchronous active-high reset
//   btn         : raw asynchronous bouncing push-button, active-high
//   blink_fast  : synchronous; selects a half-period of BLINK_HALF/4
//   state       : LED mode, 00 off / 01 on / 10 blink
//   pattern1    : blink square wave, 0 outside blink mode
//   mode_change : one-cycle pulse on every state update
// ---------------------------------------------------------------------------
module led_mode_seq #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BLINK_HALF      = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       blink_fast,
    output logic [1:0] state,
    output logic       pattern1,
    output logic       mode_change
);

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BCW-1:0] TERM_SLOW = BCW'(BLINK_HALF - 1);
    localparam logic [BCW-1:0] TERM_FAST = BCW'(BLINK_HALF / 4 - 1);

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        ON    = 2'b01,
        BLINK = 2'b10
    } mode_e;

    logic           sync1_q;
    logic           sync2_q;
    logic           dbLevel_q;
    logic           dbLevel_d;
    logic [DCW-1:0] dbCnt_q;
    logic [DCW-1:0] dbCnt_d;
    logic           dbLevelDly_q;
    logic           rise;
    mode_e          state_q;
    mode_e          state_d;
    logic           modeChange_q;
    logic           modeChange_d;
    logic [BCW-1:0] blinkCnt_q;
    logic [BCW-1:0] blinkCnt_d;
    logic [BCW-1:0] term;
    logic           pattern_q;
    logic           pattern_d;

    // Two-flop synchronizer for the asynchronous button. Only the second
    // stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: a new level is accepted only after it has differed from the
    // current debounced level for DEBOUNCE_CYCLES consecutive samples. Any
    // sample agreeing with the current level restarts the count.
    always_comb begin
        dbLevel_d = dbLevel_q;
        dbCnt_d   = '0;
        if (sync2_q != dbLevel_q) begin
            if (dbCnt_q == DCNT_LAST) begin
                dbLevel_d = sync2_q;
                dbCnt_d   = '0;
            end else begin
                dbCnt_d = dbCnt_q + DCW'(1);
            end
        end
    end

    // Debounced level, its one-cycle delay for edge detection, and the
    // debounce counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbLevel_q    <= 1'b0;
            dbLevelDly_q <= 1'b0;
            dbCnt_q      <= '0;
        end else begin
            dbLevel_q    <= dbLevel_d;
            dbLevelDly_q <= dbLevel_q;
            dbCnt_q      <= dbCnt_d;
        end
    end

    assign rise = dbLevel_q & ~dbLevelDly_q;

    // Mode stepper next state. Only rising edges of the debounced button
    // step the mode; an illegal encoding falls back to OFF on the next edge.
    // mode_change flags every edge on which the state register changes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (rise) state_d = ON;
            ON:      if (rise) state_d = BLINK;
            BLINK:   if (rise) state_d = OFF;
            default: state_d = OFF;
        endcase
        modeChange_d = (state_d != state_q);
    end

    // Blink prescaler. It runs only while staying in BLINK; on the entry edge
    // the count starts from zero so the first toggle lands a full half-period
    // later, and on the exit edge the waveform is forced low together with
    // the state change, which also gives the stepper priority over a
    // coinciding terminal count. The >= compare lets a mid-count switch to
    // the fast rate fire on the very next edge instead of wrapping.
    always_comb begin
        term       = blink_fast ? TERM_FAST : TERM_SLOW;
        blinkCnt_d = '0;
        pattern_d  = 1'b0;
        if ((state_d == BLINK) && (state_q == BLINK)) begin
            if (blinkCnt_q >= term) begin
                blinkCnt_d = '0;
                pattern_d  = ~pattern_q;
            end else begin
                blinkCnt_d = blinkCnt_q + BCW'(1);
                pattern_d  = pattern_q;
            end
        end
    end

    // Mode, pulse and blink registers; all outputs come straight from here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= OFF;
            modeChange_q <= 1'b0;
            blinkCnt_q   <= '0;
            pattern_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            modeChange_q <= modeChange_d;
            blinkCnt_q   <= blinkCnt_d;
            pattern_q    <= pattern_d;
        end
    end

    assign state       = state_q;
    assign mode_change = modeChange_q;
    assign pattern1    = pattern_q;

endmodule

// File: tb/tb_led_mode_seq.sv
// ---------------------------------------------------------------------------
// tb_led_mode_seq
//
// Directed bench for led_mode_seq with DEBOUNCE_CYCLES=4 and BLINK_HALF=8.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, so every check reflects the edge just taken. Expected
// values are hand-derived cycle by cycle: a press raised before edge k is
// accepted at edge k+6, blink toggles every 8 edges (every 2 when fast).
// ---------------------------------------------------------------------------
module tb_led_mode_seq;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       blink_fast;
    logic [1:0] state;
    logic       pattern1;
    logic       mode_change;

    int checkCount;
    int passCount;

    led_mode_seq #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_HALF     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .blink_fast (blink_fast),
        .state      (state),
        .pattern1   (pattern1),
        .mode_change(mode_change)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all inputs at once.
    task automatic applyStimulus(input logic rstVal, input logic btnVal, input logic fastVal);
        rst        = rstVal;
        btn        = btnVal;
        blink_fast = fastVal;
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One comparison of {state, pattern1, mode_change} against expectation.
    task automatic checkOutput(input string tag, input logic [1:0] expState,
                               input logic expPat, input logic expMc);
        logic [3:0] observed;
        logic [3:0] expected;
        observed = {state, pattern1, mode_change};
        expected = {expState, expPat, expMc};
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed state/pat/mc=%b/%b/%b expected %b/%b/%b",
                   tag, observed[3:2], observed[1], observed[0],
                   expected[3:2], expected[1], expected[0]);
        end
    endtask

    // Raise the button before the next edge k and hold it; the mode must not
    // move for edges k..k+5 and must step with a pulse at edge k+6.
    task automatic pressAndAccept(input string tag, input logic [1:0] fromState,
                                  input logic [1:0] toState);
        btn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stepCycles(1);
            checkOutput({tag, "_wait"}, fromState, 1'b0, 1'b0);
        end
        stepCycles(1);
        checkOutput({tag, "_accept"}, toState, 1'b0, 1'b1);
    endtask

    // Hold the button low and confirm nothing moves.
    task automatic holdReleased(input string tag, input logic [1:0] expState, input int n);
        btn = 1'b0;
        for (int i = 0; i < n; i++) begin
            stepCycles(1);
            checkOutput(tag, expState, 1'b0, 1'b0);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;

        // Reset for two edges.
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("reset", 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("idle", 2'b00, 1'b0, 1'b0);

        // Bounce: high 3, low 1, high 2, then low; must never be accepted.
        btn = 1'b1;
        stepCycles(3);
        btn = 1'b0;
        stepCycles(1);
        btn = 1'b1;
        stepCycles(2);
        btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            stepCycles(1);
            checkOutput("bounce", 2'b00, 1'b0, 1'b0);
        end

        // Clean press: OFF -> ON at k+6, pulse gone at k+7.
        pressAndAccept("press1", 2'b00, 2'b01);
        stepCycles(1);
        checkOutput("press1_pulse_end", 2'b01, 1'b0, 1'b0);
        holdReleased("release1", 2'b01, 10);

        // Second press: ON -> BLINK at edge e; button released right after.
        pressAndAccept("press2", 2'b01, 2'b10);
        btn = 1'b0;

        // Slow blink: first toggle at e+8, next at e+16.
        for (int i = 1; i <= 7; i++) begin
            stepCycles(1);
            checkOutput("blink_slow_lo", 2'b10, 1'b0, 1'b0);
        end
        stepCycles(1);
        checkOutput("blink_toggle_e8", 2'b10, 1'b1, 1'b0);
        for (int i = 9; i <= 15; i++) begin
            stepCycles(1);
            checkOutput("blink_slow_hi", 2'b10, 1'b1, 1'b0);
        end
        stepCycles(1);
        checkOutput("blink_toggle_e16", 2'b10, 1'b0, 1'b0);
        stepCycles(5);
        checkOutput("blink_cnt5", 2'b10, 1'b0, 1'b0);

        // Switch to fast with bcnt=5: toggle at e+22, then every 2 edges.
        blink_fast = 1'b1;
        stepCycles(1);
        checkOutput("fast_e22", 2'b10, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("fast_e23", 2'b10, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("fast_e24", 2'b10, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("fast_e25", 2'b10, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("fast_e26", 2'b10, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("fast_e27", 2'b10, 1'b1, 1'b0);

        // Third press raised here is accepted at e+34, the same edge on which
        // bcnt is at term with pattern1 low: the stepper must win.
        btn = 1'b1;
        stepCycles(1);
        checkOutput("coll_e28", 2'b10, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("coll_e29", 2'b10, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("coll_e30", 2'b10, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("coll_e31", 2'b10, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("coll_e32", 2'b10, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("coll_e33", 2'b10, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("coll_exit", 2'b00, 1'b0, 1'b1);
        stepCycles(1);
        checkOutput("coll_after", 2'b00, 1'b0, 1'b0);

        // Back to BLINK at slow rate for the reset-mid-operation case.
        applyStimulus(1'b0, 1'b0, 1'b0);
        holdReleased("release3", 2'b00, 10);
        pressAndAccept("press4", 2'b00, 2'b01);
        holdReleased("release4", 2'b01, 10);
        pressAndAccept("press5", 2'b01, 2'b10);
        btn = 1'b0;
        stepCycles(7);
        checkOutput("blink2_e7", 2'b10, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("blink2_e8", 2'b10, 1'b1, 1'b0);

        // Start a new press, then reset while its debounce is in progress.
        btn = 1'b1;
        stepCycles(3);
        checkOutput("pre_reset", 2'b10, 1'b1, 1'b0);
        rst = 1'b1;
        stepCycles(1);
        checkOutput("mid_reset", 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        // The still-held button needs a full acceptance window again.
        pressAndAccept("post_reset", 2'b00, 2'b01);
        stepCycles(1);
        checkOutput("post_reset_pulse_end", 2'b01, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
